// File: rtl/mem_access_if.sv
// Bundles the EX-side inputs, the data-memory req/ack bus and the WB outputs
// of the memory-access stage. The stage is the bus master.
//
// Handshake: an access is offered while MEM_REQ=1, and MEM_REQ, MEM_WE,
// MEM_ADDR, MEM_BE and MEM_WDATA stay stable until the memory answers.
// MEM_ACK=1 on a rising edge completes that access, and MEM_RDATA is sampled
// on the same edge. MEM_ACK is ignored while MEM_REQ=0.
interface mem_access_if;
  logic        IN_VALID;
  logic [31:0] Ins;
  logic [31:0] Result;
  logic [31:0] Rdata2;
  logic        STALL;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [3:0]  MEM_BE;
  logic [31:0] MEM_WDATA;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;
  logic        WB_VALID;
  logic [31:0] WB_DATA;
  logic        ADDR_ERR;
  logic        TIMEOUT_ERR;

  modport master (
    input  IN_VALID, Ins, Result, Rdata2, MEM_ACK, MEM_RDATA,
    output STALL, MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE, MEM_WDATA,
           WB_VALID, WB_DATA, ADDR_ERR, TIMEOUT_ERR
  );

  modport slave (
    output IN_VALID, Ins, Result, Rdata2, MEM_ACK, MEM_RDATA,
    input  STALL, MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE, MEM_WDATA,
           WB_VALID, WB_DATA, ADDR_ERR, TIMEOUT_ERR
  );
endinterface

// File: rtl/mem_access_stage.sv
// MIPS memory-access stage. Non-memory results pass through to WB in one
// cycle; loads and stores run one big-endian req/ack bus access, stalling
// upstream until the access completes, aborts on misalignment, or times out.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic             CLK,
  input  logic             RST,
  mem_access_if.master     bus,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          wb_valid_q, wb_valid_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          addr_err_q, addr_err_d;
  logic          tmo_err_q, tmo_err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Access attributes latched at issue, used when the read data returns.
  logic [1:0]    size_q, size_d;   // 0 byte, 1 half, 2 word
  logic          sext_q, sext_d;
  logic [1:0]    off_q, off_d;

  // Instruction decode of the op currently presented by EX.
  logic [5:0]  opc;
  logic        is_mem;
  logic        is_load;
  logic        is_sext;
  logic [1:0]  op_size;
  logic [1:0]  a;
  logic        misaligned;
  logic        unused_ins;

  assign opc        = bus.Ins[31:26];
  assign a          = bus.Result[1:0];
  assign unused_ins = ^bus.Ins[25:0];

  // Classify the opcode: memory or not, direction, width and sign handling.
  always_comb begin
    is_mem  = 1'b1;
    is_load = 1'b0;
    is_sext = 1'b0;
    op_size = 2'd0;
    case (opc)
      6'h20: begin is_load = 1'b1; is_sext = 1'b1; op_size = 2'd0; end
      6'h21: begin is_load = 1'b1; is_sext = 1'b1; op_size = 2'd1; end
      6'h23: begin is_load = 1'b1;                 op_size = 2'd2; end
      6'h24: begin is_load = 1'b1;                 op_size = 2'd0; end
      6'h25: begin is_load = 1'b1;                 op_size = 2'd1; end
      6'h28: op_size = 2'd0;
      6'h29: op_size = 2'd1;
      6'h2B: op_size = 2'd2;
      default: is_mem = 1'b0;
    endcase
    misaligned = ((op_size == 2'd1) && a[0]) || ((op_size == 2'd2) && (a != 2'd0));
  end

  // Read-data lane extraction for the latched offset and width.
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_val;
  always_comb begin
    rd_byte = 8'h00;
    case (off_q)
      2'd0: rd_byte = bus.MEM_RDATA[31:24];
      2'd1: rd_byte = bus.MEM_RDATA[23:16];
      2'd2: rd_byte = bus.MEM_RDATA[15:8];
      default: rd_byte = bus.MEM_RDATA[7:0];
    endcase
    rd_half = off_q[1] ? bus.MEM_RDATA[15:0] : bus.MEM_RDATA[31:16];
    case (size_q)
      2'd0:    rd_val = {{24{sext_q & rd_byte[7]}}, rd_byte};
      2'd1:    rd_val = {{16{sext_q & rd_half[15]}}, rd_half};
      default: rd_val = bus.MEM_RDATA;
    endcase
  end

  // Next-state and output-register logic; pulses default low every cycle.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    addr_err_d = 1'b0;
    tmo_err_d  = 1'b0;
    cnt_d      = cnt_q;
    size_d     = size_q;
    sext_d     = sext_q;
    off_d      = off_q;
    case (state_q)
      S_IDLE: begin
        if (bus.IN_VALID) begin
          if (!is_mem) begin
            wb_data_d  = bus.Result;
            wb_valid_d = 1'b1;
          end else if (misaligned) begin
            addr_err_d = 1'b1;
          end else begin
            req_d   = 1'b1;
            we_d    = ~is_load;
            addr_d  = {bus.Result[31:2], 2'b00};
            cnt_d   = '0;
            size_d  = op_size;
            sext_d  = is_sext;
            off_d   = a;
            case (op_size)
              2'd0: begin
                be_d    = 4'b1000 >> a;
                wdata_d = {4{bus.Rdata2[7:0]}};
              end
              2'd1: begin
                be_d    = a[1] ? 4'b0011 : 4'b1100;
                wdata_d = {2{bus.Rdata2[15:0]}};
              end
              default: begin
                be_d    = 4'b1111;
                wdata_d = bus.Rdata2;
              end
            endcase
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (bus.MEM_ACK) begin
          req_d      = 1'b0;
          wb_valid_d = ~we_q;
          if (!we_q) wb_data_d = rd_val;
          state_d    = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          req_d     = 1'b0;
          tmo_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      addr_err_q <= 1'b0;
      tmo_err_q  <= 1'b0;
      cnt_q      <= '0;
      size_q     <= '0;
      sext_q     <= 1'b0;
      off_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      addr_err_q <= addr_err_d;
      tmo_err_q  <= tmo_err_d;
      cnt_q      <= cnt_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      off_q      <= off_d;
    end
  end

  // Stall while an access is in flight, or while a memory op is being taken.
  assign bus.STALL = (state_q == S_ACCESS) ||
                     ((state_q == S_IDLE) && bus.IN_VALID && is_mem);

  assign bus.MEM_REQ     = req_q;
  assign bus.MEM_WE      = we_q;
  assign bus.MEM_ADDR    = addr_q;
  assign bus.MEM_BE      = be_q;
  assign bus.MEM_WDATA   = wdata_q;
  assign bus.WB_VALID    = wb_valid_q;
  assign bus.WB_DATA     = wb_data_q;
  assign bus.ADDR_ERR    = addr_err_q;
  assign bus.TIMEOUT_ERR = tmo_err_q;
  assign dbg_state_o     = state_q;

endmodule
